// File: rtl/mbank_arb_pkg.sv
// Shared types and default sizes for the two-port mbank arbiter.
// The optional WAIT timeout is enabled with MBANK_ARB_TIMEOUT_EN.
package mbank_arb_pkg;

    localparam int ADDR_W_DEF      = 5;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

endpackage

// File: rtl/mbank_rr_pick.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
// Purely combinational; the last-grant pointer is held by the caller.
module mbank_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/mbank_port_arbiter.sv
// Round-robin front end sharing one mbank controller between ports A and B.
// Define MBANK_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC cycles.
module mbank_port_arbiter
    import mbank_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef MBANK_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pa_req,
    input  logic              pa_we,
    input  logic [ADDR_W-1:0] pa_addr,
    input  logic [DATA_W-1:0] pa_wdata,
    output logic              pa_ack,
    output logic [DATA_W-1:0] pa_rdata,
    input  logic              pb_req,
    input  logic              pb_we,
    input  logic [ADDR_W-1:0] pb_addr,
    input  logic [DATA_W-1:0] pb_wdata,
    output logic              pb_ack,
    output logic [DATA_W-1:0] pb_rdata,
    output logic              err,
    output logic              mc_req,
    output logic              mc_we,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_din,
    input  logic [DATA_W-1:0] mc_dout,
    input  logic              mc_ready,
    input  logic              mc_busy
);

    state_t            state_q, state_d;
    port_sel_t         win_q, win_d;
    port_sel_t         last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick_grant, pick_valid, done;

    mbank_rr_pick u_pick (
        .req_i        ({pb_req, pa_req}),
        .last_grant_i (last_q),
        .grant_o      (pick_grant),
        .valid_o      (pick_valid)
    );

    // Writes finish once the controller drops busy; reads wait for the ready pulse.
    assign done = we_q ? ~mc_busy : mc_ready;

`ifdef MBANK_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ISSUE) begin
            tmo_d = '0;
        end else if (state_q == WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= PORT_A;
            last_q  <= PORT_B;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MBANK_ARB_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid && !mc_busy) begin
                    win_d   = port_sel_t'(pick_grant);
                    we_d    = pick_grant ? pb_we    : pa_we;
                    addr_d  = pick_grant ? pb_addr  : pa_addr;
                    wdata_d = pick_grant ? pb_wdata : pa_wdata;
                    rdata_d = '0;
`ifdef MBANK_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done) begin
                    rdata_d = we_q ? '0 : mc_dout;
                    state_d = RESP;
                end
`ifdef MBANK_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mc_req   = (state_q == ISSUE);
        mc_we    = 1'b0;
        mc_addr  = '0;
        mc_din   = '0;
        if (state_q == ISSUE || state_q == WAIT) begin
            mc_we   = we_q;
            mc_addr = addr_q;
            mc_din  = wdata_q;
        end
        pa_ack   = (state_q == RESP) && (win_q == PORT_A);
        pb_ack   = (state_q == RESP) && (win_q == PORT_B);
        pa_rdata = pa_ack ? rdata_q : '0;
        pb_rdata = pb_ack ? rdata_q : '0;
`ifdef MBANK_ARB_TIMEOUT_EN
        err      = err_q & (state_q == RESP);
`else
        err      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mbank_port_arbiter.sv
// Directed bench for mbank_port_arbiter with a behavioural 2-cycle bank controller.
// Build with MBANK_ARB_TIMEOUT_EN to exercise the WAIT timeout path.
module tb_mbank_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pa_req, pa_we, pb_req, pb_we;
    logic [4:0] pa_addr, pb_addr;
    logic [7:0] pa_wdata, pb_wdata, pa_rdata, pb_rdata;
    logic       pa_ack, pb_ack, err;
    logic       mc_req, mc_we, mc_ready, mc_busy;
    logic [4:0] mc_addr;
    logic [7:0] mc_din, mc_dout;

    int total = 0;
    int bad = 0;
    bit stall = 1'b0;

    always #5 clk = ~clk;

    mbank_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pa_req   (pa_req),
        .pa_we    (pa_we),
        .pa_addr  (pa_addr),
        .pa_wdata (pa_wdata),
        .pa_ack   (pa_ack),
        .pa_rdata (pa_rdata),
        .pb_req   (pb_req),
        .pb_we    (pb_we),
        .pb_addr  (pb_addr),
        .pb_wdata (pb_wdata),
        .pb_ack   (pb_ack),
        .pb_rdata (pb_rdata),
        .err      (err),
        .mc_req   (mc_req),
        .mc_we    (mc_we),
        .mc_addr  (mc_addr),
        .mc_din   (mc_din),
        .mc_dout  (mc_dout),
        .mc_ready (mc_ready),
        .mc_busy  (mc_busy)
    );

    // Controller model: busy for 2 cycles after a request, then a ready pulse for reads.
    logic [7:0] mem [32];
    logic [1:0] cnt_m;
    logic       we_m;
    logic [4:0] addr_m;
    logic [7:0] din_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_busy  <= 1'b0;
            mc_ready <= 1'b0;
            mc_dout  <= 8'h00;
            cnt_m    <= 2'd0;
        end else begin
            mc_ready <= 1'b0;
            if (mc_busy) begin
                if (cnt_m == 2'd1) begin
                    mc_busy <= 1'b0;
                    if (we_m) mem[addr_m] <= din_m;
                    else begin
                        mc_ready <= 1'b1;
                        mc_dout  <= mem[addr_m];
                    end
                end else begin
                    cnt_m <= cnt_m - 2'd1;
                end
            end else if (mc_req && !stall) begin
                mc_busy <= 1'b1;
                cnt_m   <= 2'd2;
                we_m    <= mc_we;
                addr_m  <= mc_addr;
                din_m   <= mc_din;
            end
        end
    end

    typedef struct {
        bit         p;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[66];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_port(input bit p, input bit rq, input bit we, input logic [4:0] a, input logic [7:0] d);
        if (!p) begin
            pa_req = rq; pa_we = we; pa_addr = a; pa_wdata = d;
        end else begin
            pb_req = rq; pb_we = we; pb_addr = a; pb_wdata = d;
        end
    endtask

    task automatic do_txn(input string nm, input bit p, input bit we, input logic [4:0] a,
                          input logic [7:0] d, input logic [7:0] exp, input int exp_cyc, input bit exp_err);
        int cyc = 0;
        int nreq = 0;
        bit got = 1'b0;
        bit other = 1'b0;
        logic [7:0] rd = 8'h00;
        logic e = 1'b0;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, d);
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (mc_req) nreq++;
            if (p ? pa_ack : pb_ack) other = 1'b1;
            if (p ? pb_ack : pa_ack) begin
                got = 1'b1;
                rd  = p ? pb_rdata : pa_rdata;
                e   = err;
            end
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 5'd0, 8'h00);
        $display("txn %s port=%s we=%0d addr=%0d rdata=%02h err=%0d cycles=%0d",
                 nm, p ? "B" : "A", we, a, rd, e, cyc);
        chk({nm, ".ack"}, 32'(got), 32'd1);
        chk({nm, ".latency"}, cyc, exp_cyc);
        chk({nm, ".rdata"}, 32'(rd), 32'(exp));
        chk({nm, ".err"}, 32'(e), 32'(exp_err));
        chk({nm, ".mc_req_pulses"}, nreq, 1);
        chk({nm, ".other_ack"}, 32'(other), 32'd0);
    endtask

    task automatic dual(input string nm, input int na_in, input int nb_in,
                        input logic [7:0] exp_a, input logic [7:0] exp_b, input string exp_ord);
        int na = na_in;
        int nb = nb_in;
        int cyc = 0;
        bit both = 1'b0;
        string ord = "";
        while ((na > 0 || nb > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (pa_ack && pb_ack) both = 1'b1;
            if (pa_ack) begin
                ord = {ord, "A"};
                na--;
                chk({nm, ".rdata_a"}, 32'(pa_rdata), 32'(exp_a));
            end
            if (pb_ack) begin
                ord = {ord, "B"};
                nb--;
                chk({nm, ".rdata_b"}, 32'(pb_rdata), 32'(exp_b));
            end
            @(posedge clk); #1;
            if (na <= 0) pa_req = 1'b0;
            if (nb <= 0) pb_req = 1'b0;
        end
        $display("txn %s order=%s cycles=%0d", nm, ord, cyc);
        total++;
        if (ord != exp_ord) begin
            bad++;
            $display("FAIL %s.order: got %s expected %s", nm, ord, exp_ord);
        end
        chk({nm, ".simultaneous_ack"}, 32'(both), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int cyc;
        set_port(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        set_port(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        vecs[0] = '{p: 1'b0, we: 1'b1, addr: 5'd3, wdata: 8'hA5, exp: 8'h00};
        vecs[1] = '{p: 1'b0, we: 1'b0, addr: 5'd3, wdata: 8'h00, exp: 8'hA5};
        for (int i = 0; i < 32; i++) begin
            vecs[2 + i]  = '{p: i[0],  we: 1'b1, addr: 5'(i), wdata: 8'(i), exp: 8'h00};
            vecs[34 + i] = '{p: ~i[0], we: 1'b0, addr: 5'(i), wdata: 8'h00, exp: 8'(i)};
        end

        repeat (2) @(negedge clk);
        chk("reset.outputs", {mc_req, mc_we, mc_addr, mc_din, pa_ack, pb_ack, pa_rdata, pb_rdata, err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Port A write then read back
        for (int i = 0; i < 2; i++)
            do_txn($sformatf("t1_v%0d", i), vecs[i].p, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp, 6, 1'b0);

        // Simultaneous first requests after reset: A wins the tie
        do_reset();
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 5'd1, 8'h11);
        set_port(1'b1, 1'b1, 1'b1, 5'd2, 8'h22);
        dual("t2_tie", 1, 1, 8'h00, 8'h00, "AB");
        do_txn("t2_rdA", 1'b0, 1'b0, 5'd1, 8'h00, 8'h11, 6, 1'b0);
        do_txn("t2_rdB", 1'b1, 1'b0, 5'd2, 8'h00, 8'h22, 6, 1'b0);

        // Both holding req: strict alternation
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 5'd1, 8'h00);
        set_port(1'b1, 1'b1, 1'b0, 5'd2, 8'h00);
        dual("t3_alt", 4, 4, 8'h11, 8'h22, "ABABABAB");

        // Fill and read back every address through alternating ports
        for (int i = 2; i < 66; i++)
            do_txn($sformatf("t4_v%0d", i), vecs[i].p, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp, 6, 1'b0);

        // Reset during WAIT of a read aborts without ack
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
        repeat (3) @(negedge clk);
        chk("t5.wait_addr", 32'(mc_addr), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5.outputs_zero", {mc_req, mc_we, mc_addr, mc_din, pa_ack, pb_ack, pa_rdata, pb_rdata, err}, 32'd0);
        set_port(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        acc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            acc |= pa_ack | pb_ack;
        end
        chk("t5.no_ack", 32'(acc), 32'd0);
        do_txn("t5_after", 1'b0, 1'b0, 5'd5, 8'h00, 8'h05, 6, 1'b0);

        // req dropped before ack still completes
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 5'd7, 8'h77);
        repeat (2) @(negedge clk);
        set_port(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            cyc++;
            acc = pa_ack;
        end
        $display("txn early_drop ack=%0d cycles=%0d", acc, cyc);
        chk("drop.ack", 32'(acc), 32'd1);
        do_txn("drop_rd", 1'b1, 1'b0, 5'd7, 8'h00, 8'h77, 6, 1'b0);

        // Controller that never completes a read
        stall = 1'b1;
`ifdef MBANK_ARB_TIMEOUT_EN
        do_txn("t6_tmo", 1'b0, 1'b0, 5'd4, 8'h00, 8'h00, 19, 1'b1);
        stall = 1'b0;
        do_txn("t6_after", 1'b1, 1'b0, 5'd4, 8'h00, 8'h04, 6, 1'b0);
`else
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 5'd4, 8'h00);
        acc = 1'b0;
        repeat (40) begin
            @(negedge clk);
            acc |= pa_ack | pb_ack | err;
        end
        $display("txn t6_stall ack_or_err=%0d mc_addr=%0d", acc, mc_addr);
        chk("t6.no_ack_no_err", 32'(acc), 32'd0);
        chk("t6.addr_held", 32'(mc_addr), 32'd4);
        set_port(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        stall = 1'b0;
        do_reset();
        do_txn("t6_after", 1'b1, 1'b0, 5'd4, 8'h00, 8'h04, 6, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
